// File: rtl/rvfi_retire_serializer_pkg.sv
// Shared RVFI packet layout for the retire serializer, the core wrapper and the checker wrapper.
// Fields are packed MSB..LSB in the order of rvfi_pkt32_t, so the order tag always sits in the low byte.
package rvfi_retire_serializer_pkg;

  localparam int ORDER_W   = 8;
  localparam int ORDER_LSB = 0;

  // order + insn + rs1/rs2/rd addresses + trap, eight XLEN words, two byte masks
  function automatic int pkt_w(input int xlen);
    return 56 + 8 * xlen + xlen / 4;
  endfunction

  typedef struct packed {
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic [3:0]         mem_wmask;
    logic [3:0]         mem_rmask;
    logic [31:0]        mem_addr;
    logic               post_trap;
    logic [31:0]        post_rd;
    logic [31:0]        post_pc;
    logic [31:0]        pre_rs2;
    logic [31:0]        pre_rs1;
    logic [31:0]        pre_pc;
    logic [4:0]         rd;
    logic [4:0]         rs2;
    logic [4:0]         rs1;
    logic [31:0]        insn;
    logic [ORDER_W-1:0] order;
  } rvfi_pkt32_t;

endpackage

// File: rtl/rvfi_retire_serializer_if.sv
// Multi-channel retire input, single-channel checker output and status of the retire serializer.
interface rvfi_retire_serializer_if import rvfi_retire_serializer_pkg::*; #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) ();

  localparam int PKT_W = pkt_w(XLEN);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                  enable;
  logic [NRET-1:0]       in_valid;
  logic [NRET*PKT_W-1:0] in_pkt;
  logic                  out_ready;
  logic                  out_valid;
  logic [PKT_W-1:0]      out_pkt;
  logic [LVL_W-1:0]      level;
  logic                  overflow;
  logic                  order_err;

  modport master (
    output enable, in_valid, in_pkt, out_ready,
    input  out_valid, out_pkt, level, overflow, order_err
  );

  modport slave (
    input  enable, in_valid, in_pkt, out_ready,
    output out_valid, out_pkt, level, overflow, order_err
  );

endinterface

// File: rtl/rvfi_retire_serializer_compact.sv
// Prefix count of the retire valids: each channel's slot offset from wr_ptr and the group size.
module rvfi_retire_serializer_compact #(
  parameter int NRET  = 2,
  parameter int CNT_W = $clog2(NRET + 1)
) (
  input  logic                       enable,
  input  logic [NRET-1:0]            in_valid,
  output logic [NRET-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]           n
);

  logic [CNT_W-1:0] acc;

  // Lower channel index is the older retirement, so it takes the lower slot.
  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < NRET; i++) begin
      offset[i] = acc;
      if (enable && in_valid[i]) acc = acc + CNT_W'(1);
    end
    n = acc;
  end

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Buffers NRET-wide RVFI retirements in a circular FIFO and replays them one per cycle to a
// single-channel checker, flagging dropped groups (overflow) and order discontinuities (order_err).
module rvfi_retire_serializer import rvfi_retire_serializer_pkg::*; #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input logic                     clk,
  input logic                     resetn,
  rvfi_retire_serializer_if.slave bus
);

  localparam int PKT_W = pkt_w(XLEN);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NRET + 1);

  logic [PKT_W-1:0]           mem [DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [LVL_W-1:0]           level;
  logic                       overflow;
  logic                       order_err;
  logic [ORDER_W-1:0]         exp_order;
  logic                       exp_valid;

  logic [NRET-1:0][CNT_W-1:0] offset;
  logic [CNT_W-1:0]           n;
  logic                       pop;
  logic [LVL_W:0]             free;
  logic                       drop;
  logic [ORDER_W-1:0]         head_order;
  logic [LVL_W-1:0]           add_cnt;
  logic [LVL_W-1:0]           sub_cnt;

  rvfi_retire_serializer_compact #(.NRET(NRET), .CNT_W(CNT_W)) u_compact (
    .enable   (bus.enable),
    .in_valid (bus.in_valid),
    .offset   (offset),
    .n        (n)
  );

  assign pop        = (level != '0) && bus.out_ready;
  // A slot freed by this cycle's pop is reusable by this cycle's push.
  assign free       = (LVL_W+1)'(DEPTH) - {1'b0, level} + {{LVL_W{1'b0}}, pop};
  assign drop       = (LVL_W+1)'(n) > free;
  assign head_order = mem[rd_ptr][ORDER_LSB +: ORDER_W];
  assign add_cnt    = drop ? '0 : LVL_W'(n);
  assign sub_cnt    = {{(LVL_W-1){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (!drop) begin
      for (int i = 0; i < NRET; i++) begin
        if (bus.enable && bus.in_valid[i])
          mem[wr_ptr + PTR_W'(offset[i])] <= bus.in_pkt[i*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
      exp_order <= '0;
      exp_valid <= 1'b0;
    end else begin
      if (!drop) wr_ptr <= wr_ptr + PTR_W'(n);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + add_cnt - sub_cnt;
      if (drop) overflow <= 1'b1;
      // Resynchronise on every pop so one gap is reported once, not on every later packet.
      if (pop) begin
        if (exp_valid && (head_order != exp_order)) order_err <= 1'b1;
        exp_order <= head_order + ORDER_W'(1);
        exp_valid <= 1'b1;
      end
    end
  end

  assign bus.out_valid = (level != '0);
  assign bus.out_pkt   = mem[rd_ptr];
  assign bus.level     = level;
  assign bus.overflow  = overflow;
  assign bus.order_err = order_err;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Randomised and directed bench for rvfi_retire_serializer against a queue-based reference model.
module tb_rvfi_retire_serializer;
  import rvfi_retire_serializer_pkg::*;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int PKT_W = pkt_w(XLEN);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rvfi_retire_serializer_if #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  logic [PKT_W-1:0] mq[$];
  bit               m_ovf;
  bit               m_oerr;
  bit               m_expv;
  logic [7:0]       m_exp;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk(input logic [7:0] ord);
    rvfi_pkt32_t p;
    logic [PKT_W-1:0] r;
    for (int k = 0; k < PKT_W / 32; k++) r[k*32 +: 32] = $urandom;
    p = r;
    p.order = ord;
    return p;
  endfunction

  // Advance the model by one clock from the current inputs, clock the DUT, then compare.
  task automatic cycle();
    int n;
    bit pop;
    int free;
    logic [7:0] ord;
    if (!resetn) begin
      mq.delete();
      m_ovf = 0; m_oerr = 0; m_expv = 0; m_exp = 8'd0;
    end else begin
      n    = bus.enable ? $countones(bus.in_valid) : 0;
      pop  = (mq.size() > 0) && bus.out_ready;
      free = DEPTH - mq.size() + (pop ? 1 : 0);
      if (pop) begin
        ord = mq[0][7:0];
        if (m_expv && ord != m_exp) m_oerr = 1;
        m_exp  = ord + 8'd1;
        m_expv = 1;
        void'(mq.pop_front());
      end
      if (n > free) m_ovf = 1;
      else
        for (int i = 0; i < NRET; i++)
          if (bus.enable && bus.in_valid[i]) mq.push_back(bus.in_pkt[i*PKT_W +: PKT_W]);
    end
    @(posedge clk);
    #1;
    check("level", bus.level, mq.size());
    check("out_valid", bus.out_valid, mq.size() != 0);
    if (mq.size() != 0) check("out_pkt", bus.out_pkt, mq[0]);
    check("overflow", bus.overflow, m_ovf);
    check("order_err", bus.order_err, m_oerr);
  endtask

  task automatic drive(input bit en, input logic [1:0] v, input logic [7:0] o0,
                       input logic [7:0] o1, input bit rdy);
    bus.enable    = en;
    bus.in_valid  = v;
    bus.in_pkt    = {mk(o1), mk(o0)};
    bus.out_ready = rdy;
    cycle();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(1'b1, 2'b00, 8'd0, 8'd0, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] nxt;
    logic [7:0] o0;
    logic [7:0] o1;
    bit en;
    logic [1:0] v;
    bit rdy_hi;

    bus.enable = 1'b0; bus.in_valid = '0; bus.in_pkt = '0; bus.out_ready = 1'b0;
    do_reset();
    do_reset();
    check("rst_level", bus.level, 0);
    check("rst_flags", {bus.overflow, bus.order_err, bus.out_valid}, 3'b000);

    // single packet, one cycle latency
    drive(1, 2'b01, 8'd5, 8'd0, 1);
    check("single_order", bus.out_pkt[7:0], 8'd5);
    drive(1, 2'b00, 8'd0, 8'd0, 1);
    check("single_drain", bus.level, 0);

    // two channels in one cycle, ch0 older
    do_reset();
    drive(1, 2'b11, 8'd10, 8'd11, 0);
    check("pair_level", bus.level, 2);
    drive(1, 2'b00, 8'd0, 8'd0, 1);
    check("pair_second", bus.out_pkt[7:0], 8'd11);
    drive(1, 2'b00, 8'd0, 8'd0, 1);
    check("pair_noerr", bus.order_err, 0);

    // fill to 7, drop a pair, then push one alongside a pop
    do_reset();
    drive(1, 2'b11, 8'd50, 8'd51, 0);
    drive(1, 2'b11, 8'd52, 8'd53, 0);
    drive(1, 2'b11, 8'd54, 8'd55, 0);
    drive(1, 2'b01, 8'd56, 8'd0, 0);
    drive(1, 2'b11, 8'd57, 8'd58, 0);
    check("ovf_set", bus.overflow, 1);
    check("ovf_level", bus.level, 7);
    drive(1, 2'b01, 8'd59, 8'd0, 1);
    check("pushpop_level", bus.level, 7);
    for (int k = 0; k < 8; k++) drive(1, 2'b00, 8'd0, 8'd0, 1);
    check("ovf_sticky", bus.overflow, 1);
    check("gap_err", bus.order_err, 1);

    // order wrap, then a gap
    do_reset();
    drive(1, 2'b01, 8'd254, 8'd0, 1);
    drive(1, 2'b01, 8'd255, 8'd0, 1);
    drive(1, 2'b01, 8'd0, 8'd0, 1);
    drive(1, 2'b01, 8'd1, 8'd0, 1);
    drive(1, 2'b00, 8'd0, 8'd0, 1);
    check("wrap_noerr", bus.order_err, 0);
    drive(1, 2'b01, 8'd3, 8'd0, 1);
    drive(1, 2'b00, 8'd0, 8'd0, 1);
    check("gap3_err", bus.order_err, 1);
    drive(1, 2'b00, 8'd0, 8'd0, 1);
    check("gap3_sticky", bus.order_err, 1);

    // enable low freezes push, drain continues
    do_reset();
    drive(1, 2'b11, 8'd20, 8'd21, 0);
    drive(1, 2'b11, 8'd22, 8'd23, 0);
    for (int k = 0; k < 3; k++) drive(0, 2'b11, 8'd90, 8'd91, 1);
    check("en_low_level", bus.level, 1);

    // mid-operation reset flush
    do_reset();
    drive(1, 2'b11, 8'd30, 8'd31, 0);
    drive(1, 2'b11, 8'd32, 8'd33, 0);
    drive(1, 2'b01, 8'd34, 8'd0, 0);
    check("pre_rst_level", bus.level, 5);
    do_reset();
    check("flush_state", {bus.level, bus.out_valid, bus.overflow, bus.order_err}, 0);
    drive(1, 2'b01, 8'd40, 8'd0, 1);
    drive(1, 2'b01, 8'd41, 8'd0, 1);
    drive(1, 2'b00, 8'd0, 8'd0, 1);
    check("post_rst_noerr", bus.order_err, 0);

    // randomised traffic with bursty back-pressure and occasional gaps and resets
    nxt = 8'($urandom);
    rdy_hi = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) rdy_hi = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        en = $urandom_range(0, 7) != 0;
        v  = 2'($urandom);
        if ($urandom_range(0, 31) == 0) nxt = nxt + 8'd3;
        o0 = nxt;
        if (en && v[0]) nxt = nxt + 8'd1;
        o1 = nxt;
        if (en && v[1]) nxt = nxt + 8'd1;
        drive(en, v, o0, o1, rdy_hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
